// File: rtl/arb_pkg.sv
// Shared types and widths for the main memory arbiter.
// Optional build macro: ROUND_ROBIN_ARB_EN.
package arb_pkg;
    localparam int MEM_ADDR_W  = 28;
    localparam int MEM_BLOCK_W = 128;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        GRANT_I = 2'b01,
        GRANT_D = 2'b10
    } state_t;
endpackage

// File: rtl/main_memory_arbiter_if.sv
// Cache-side and memory-side buses of the main memory arbiter.
// slave is the arbiter's view; master is the environment's view.
interface main_memory_arbiter_if;
    import arb_pkg::*;

    logic                   ICACHE_MEM_READ;
    logic [MEM_ADDR_W-1:0]  ICACHE_MEM_ADDRESS;
    logic [MEM_BLOCK_W-1:0] ICACHE_MEM_READ_DATA;
    logic                   ICACHE_MEM_BUSY_WAIT;

    logic                   DCACHE_MEM_READ;
    logic                   DCACHE_MEM_WRITE;
    logic [MEM_ADDR_W-1:0]  DCACHE_MEM_ADDRESS;
    logic [MEM_BLOCK_W-1:0] DCACHE_MEM_WRITE_DATA;
    logic [MEM_BLOCK_W-1:0] DCACHE_MEM_READ_DATA;
    logic                   DCACHE_MEM_BUSY_WAIT;

    logic                   MAIN_MEM_READ;
    logic                   MAIN_MEM_WRITE;
    logic [MEM_ADDR_W-1:0]  MAIN_MEM_ADDRESS;
    logic [MEM_BLOCK_W-1:0] MAIN_MEM_WRITE_DATA;
    logic [MEM_BLOCK_W-1:0] MAIN_MEM_READ_DATA;
    logic                   MAIN_MEM_BUSY_WAIT;

    modport slave (
        input  ICACHE_MEM_READ, ICACHE_MEM_ADDRESS,
        output ICACHE_MEM_READ_DATA, ICACHE_MEM_BUSY_WAIT,
        input  DCACHE_MEM_READ, DCACHE_MEM_WRITE,
        input  DCACHE_MEM_ADDRESS, DCACHE_MEM_WRITE_DATA,
        output DCACHE_MEM_READ_DATA, DCACHE_MEM_BUSY_WAIT,
        output MAIN_MEM_READ, MAIN_MEM_WRITE,
        output MAIN_MEM_ADDRESS, MAIN_MEM_WRITE_DATA,
        input  MAIN_MEM_READ_DATA, MAIN_MEM_BUSY_WAIT
    );

    modport master (
        output ICACHE_MEM_READ, ICACHE_MEM_ADDRESS,
        input  ICACHE_MEM_READ_DATA, ICACHE_MEM_BUSY_WAIT,
        output DCACHE_MEM_READ, DCACHE_MEM_WRITE,
        output DCACHE_MEM_ADDRESS, DCACHE_MEM_WRITE_DATA,
        input  DCACHE_MEM_READ_DATA, DCACHE_MEM_BUSY_WAIT,
        input  MAIN_MEM_READ, MAIN_MEM_WRITE,
        input  MAIN_MEM_ADDRESS, MAIN_MEM_WRITE_DATA,
        output MAIN_MEM_READ_DATA, MAIN_MEM_BUSY_WAIT
    );
endinterface

// File: rtl/arb_grant_select.sv
// Combinational pick between I and D requests in IDLE.
// ROUND_ROBIN_ARB_EN: alternate on contention; otherwise D wins.
module arb_grant_select (
    input  logic i_req,
    input  logic d_req,
`ifdef ROUND_ROBIN_ARB_EN
    input  logic last_d,
`endif
    output logic pick_i,
    output logic pick_d
);
`ifdef ROUND_ROBIN_ARB_EN
    assign pick_d = d_req && (!i_req || !last_d);
    assign pick_i = i_req && (!d_req || last_d);
`else
    assign pick_d = d_req;
    assign pick_i = i_req && !d_req;
`endif
endmodule

// File: rtl/main_memory_arbiter.sv
// Two-port (I/D cache) arbiter in front of a single main memory.
// Optional build macro: ROUND_ROBIN_ARB_EN (round-robin instead of D priority).
module main_memory_arbiter
    import arb_pkg::*;
(
    input  logic                  clock,
    input  logic                  reset,
    main_memory_arbiter_if.slave  bus
);
    state_t state, state_nxt;
    logic   issued, issued_nxt;
    logic   i_req, d_req, pick_i, pick_d, done;
    logic   d_wr, d_rd;

    assign i_req = bus.ICACHE_MEM_READ;
    assign d_wr  = bus.DCACHE_MEM_WRITE;
    assign d_rd  = bus.DCACHE_MEM_READ && !bus.DCACHE_MEM_WRITE;
    assign d_req = bus.DCACHE_MEM_READ || bus.DCACHE_MEM_WRITE;
    assign done  = issued && !bus.MAIN_MEM_BUSY_WAIT && (state != IDLE);

`ifdef ROUND_ROBIN_ARB_EN
    logic last_d;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            last_d <= 1'b1;
        end else if (state == IDLE && (pick_i || pick_d)) begin
            last_d <= pick_d;
        end
    end

    arb_grant_select u_sel (
        .i_req  (i_req),
        .d_req  (d_req),
        .last_d (last_d),
        .pick_i (pick_i),
        .pick_d (pick_d)
    );
`else
    arb_grant_select u_sel (
        .i_req  (i_req),
        .d_req  (d_req),
        .pick_i (pick_i),
        .pick_d (pick_d)
    );
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            issued <= 1'b0;
        end else begin
            state  <= state_nxt;
            issued <= issued_nxt;
        end
    end

    // A dropped request (abort) and a completion both return to IDLE.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (pick_d)      state_nxt = GRANT_D;
                else if (pick_i) state_nxt = GRANT_I;
            end
            GRANT_I: if (!i_req || done) state_nxt = IDLE;
            GRANT_D: if (!d_req || done) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        issued_nxt = (state != IDLE) && (state_nxt != IDLE);
    end

    always_comb begin
        bus.MAIN_MEM_READ       = 1'b0;
        bus.MAIN_MEM_WRITE      = 1'b0;
        bus.MAIN_MEM_ADDRESS    = '0;
        bus.MAIN_MEM_WRITE_DATA = '0;
        unique case (1'b1)
            (state == GRANT_I): begin
                bus.MAIN_MEM_READ    = i_req;
                bus.MAIN_MEM_ADDRESS = bus.ICACHE_MEM_ADDRESS;
            end
            (state == GRANT_D): begin
                bus.MAIN_MEM_READ       = d_rd;
                bus.MAIN_MEM_WRITE      = d_wr;
                bus.MAIN_MEM_ADDRESS    = bus.DCACHE_MEM_ADDRESS;
                bus.MAIN_MEM_WRITE_DATA = bus.DCACHE_MEM_WRITE_DATA;
            end
            default: ;
        endcase
    end

    assign bus.ICACHE_MEM_BUSY_WAIT = i_req && !(state == GRANT_I && done);
    assign bus.DCACHE_MEM_BUSY_WAIT = d_req && !(state == GRANT_D && done);
    assign bus.ICACHE_MEM_READ_DATA = bus.MAIN_MEM_READ_DATA;
    assign bus.DCACHE_MEM_READ_DATA = bus.MAIN_MEM_READ_DATA;
endmodule

// File: tb/tb_main_memory_arbiter.sv
// Directed bench for main_memory_arbiter with a 4-cycle-busy memory model.
// Builds with or without ROUND_ROBIN_ARB_EN.
module tb_main_memory_arbiter;
    import arb_pkg::*;

    localparam logic [127:0] RDATA = 128'hDEADBEEF_01234567_89ABCDEF_0000CAFE;
    localparam logic [127:0] WBLK  = 128'h11112222_33334444_55556666_77778888;
    localparam logic [3:0]   LAT   = 4'd4;

    logic clk = 1'b0;
    logic rst_n;
    logic [3:0] cnt = '0;
    int checks = 0;
    int failures = 0;

    main_memory_arbiter_if bus ();

    main_memory_arbiter dut (
        .clock (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Memory stays busy for LAT cycles of an access, then drops busy for one.
    assign bus.MAIN_MEM_BUSY_WAIT =
        (bus.MAIN_MEM_READ || bus.MAIN_MEM_WRITE) && (cnt < LAT);
    assign bus.MAIN_MEM_READ_DATA = RDATA;

    always @(posedge clk) begin
        if (!(bus.MAIN_MEM_READ || bus.MAIN_MEM_WRITE) || !bus.MAIN_MEM_BUSY_WAIT)
            cnt <= '0;
        else
            cnt <= cnt + 4'd1;
    end

    task automatic test_reset();
        rst_n = 1'b0;
        bus.ICACHE_MEM_READ = 1'b0;
        bus.ICACHE_MEM_ADDRESS = '0;
        bus.DCACHE_MEM_READ = 1'b0;
        bus.DCACHE_MEM_WRITE = 1'b0;
        bus.DCACHE_MEM_ADDRESS = '0;
        bus.DCACHE_MEM_WRITE_DATA = '0;
        repeat (2) @(negedge clk);
        checks++;
        if (dut.state !== IDLE) begin
            failures++;
            $display("FAIL rst_state got=%0d exp=%0d", dut.state, IDLE);
        end
        checks++;
        if (bus.MAIN_MEM_READ !== 1'b0 || bus.MAIN_MEM_WRITE !== 1'b0) begin
            failures++;
            $display("FAIL rst_mem_rw got=%b%b exp=00",
                     bus.MAIN_MEM_READ, bus.MAIN_MEM_WRITE);
        end
        checks++;
        if (bus.ICACHE_MEM_BUSY_WAIT !== 1'b0 || bus.DCACHE_MEM_BUSY_WAIT !== 1'b0) begin
            failures++;
            $display("FAIL rst_busy_idle got=%b%b exp=00",
                     bus.ICACHE_MEM_BUSY_WAIT, bus.DCACHE_MEM_BUSY_WAIT);
        end
        bus.DCACHE_MEM_READ = 1'b1;
        #1;
        checks++;
        if (bus.DCACHE_MEM_BUSY_WAIT !== 1'b1 || bus.MAIN_MEM_READ !== 1'b0) begin
            failures++;
            $display("FAIL rst_busy_req got=%b rd=%b exp busy=1 rd=0",
                     bus.DCACHE_MEM_BUSY_WAIT, bus.MAIN_MEM_READ);
        end
        bus.DCACHE_MEM_READ = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (dut.state !== IDLE) begin
            failures++;
            $display("FAIL rst_release_state got=%0d exp=%0d", dut.state, IDLE);
        end
    endtask

    task automatic test_single_i();
        int done_at = -1;
        @(posedge clk); #1;
        bus.ICACHE_MEM_READ = 1'b1;
        bus.ICACHE_MEM_ADDRESS = 28'hABC1230;
        @(negedge clk);
        checks++;
        if (dut.state !== IDLE || bus.ICACHE_MEM_BUSY_WAIT !== 1'b1 ||
            bus.MAIN_MEM_READ !== 1'b0) begin
            failures++;
            $display("FAIL single_c0 got st=%0d busy=%b rd=%b exp st=0 busy=1 rd=0",
                     dut.state, bus.ICACHE_MEM_BUSY_WAIT, bus.MAIN_MEM_READ);
        end
        @(negedge clk);
        checks++;
        if (dut.state !== GRANT_I || bus.MAIN_MEM_READ !== 1'b1 ||
            bus.MAIN_MEM_ADDRESS !== 28'hABC1230 ||
            bus.ICACHE_MEM_BUSY_WAIT !== 1'b1) begin
            failures++;
            $display("FAIL single_grant got st=%0d rd=%b a=%h busy=%b exp st=1 rd=1 a=abc1230 busy=1",
                     dut.state, bus.MAIN_MEM_READ, bus.MAIN_MEM_ADDRESS,
                     bus.ICACHE_MEM_BUSY_WAIT);
        end
        for (int c = 2; c < 20; c++) begin
            @(negedge clk);
            if (!bus.ICACHE_MEM_BUSY_WAIT) begin
                done_at = c;
                checks++;
                if (bus.ICACHE_MEM_READ_DATA !== RDATA) begin
                    failures++;
                    $display("FAIL single_data got=%h exp=%h",
                             bus.ICACHE_MEM_READ_DATA, RDATA);
                end
                break;
            end
        end
        checks++;
        if (done_at != 5) begin
            failures++;
            $display("FAIL single_latency got=%0d exp=5", done_at);
        end
        @(posedge clk); #1;
        bus.ICACHE_MEM_READ = 1'b0;
        @(negedge clk);
        checks++;
        if (dut.state !== IDLE || bus.ICACHE_MEM_BUSY_WAIT !== 1'b0) begin
            failures++;
            $display("FAIL single_end got st=%0d busy=%b exp st=0 busy=0",
                     dut.state, bus.ICACHE_MEM_BUSY_WAIT);
        end
    endtask

`ifndef ROUND_ROBIN_ARB_EN
    task automatic test_fixed_priority();
        int done_at = -1;
        bit i_held = 1'b1;
        @(posedge clk); #1;
        bus.ICACHE_MEM_READ = 1'b1;
        bus.ICACHE_MEM_ADDRESS = 28'h0000100;
        bus.DCACHE_MEM_READ = 1'b1;
        bus.DCACHE_MEM_ADDRESS = 28'h0000200;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (dut.state !== GRANT_D || bus.MAIN_MEM_ADDRESS !== 28'h0000200) begin
            failures++;
            $display("FAIL prio_first got st=%0d a=%h exp st=2 a=0000200",
                     dut.state, bus.MAIN_MEM_ADDRESS);
        end
        if (!bus.ICACHE_MEM_BUSY_WAIT) i_held = 1'b0;
        for (int c = 2; c < 20; c++) begin
            @(negedge clk);
            if (!bus.ICACHE_MEM_BUSY_WAIT) i_held = 1'b0;
            if (!bus.DCACHE_MEM_BUSY_WAIT) begin
                done_at = c;
                break;
            end
        end
        checks++;
        if (done_at != 5 || !i_held) begin
            failures++;
            $display("FAIL prio_d_done got at=%0d i_held=%b exp at=5 i_held=1",
                     done_at, i_held);
        end
        @(posedge clk); #1;
        bus.DCACHE_MEM_READ = 1'b0;
        @(negedge clk);
        checks++;
        if (dut.state !== IDLE || bus.ICACHE_MEM_BUSY_WAIT !== 1'b1) begin
            failures++;
            $display("FAIL prio_gap got st=%0d busy=%b exp st=0 busy=1",
                     dut.state, bus.ICACHE_MEM_BUSY_WAIT);
        end
        @(negedge clk);
        checks++;
        if (dut.state !== GRANT_I || bus.MAIN_MEM_ADDRESS !== 28'h0000100) begin
            failures++;
            $display("FAIL prio_second got st=%0d a=%h exp st=1 a=0000100",
                     dut.state, bus.MAIN_MEM_ADDRESS);
        end
        done_at = -1;
        for (int c = 2; c < 20; c++) begin
            @(negedge clk);
            if (!bus.ICACHE_MEM_BUSY_WAIT) begin
                done_at = c;
                break;
            end
        end
        checks++;
        if (done_at != 5) begin
            failures++;
            $display("FAIL prio_i_done got=%0d exp=5", done_at);
        end
        @(posedge clk); #1;
        bus.ICACHE_MEM_READ = 1'b0;
        @(negedge clk);
    endtask
`else
    task automatic test_round_robin();
        state_t exp_st;
        int done_at;
        for (int p = 0; p < 3; p++) begin
            exp_st = (p % 2 == 0) ? GRANT_D : GRANT_I;
            @(posedge clk); #1;
            bus.ICACHE_MEM_READ = 1'b1;
            bus.DCACHE_MEM_READ = 1'b1;
            @(negedge clk);
            @(negedge clk);
            checks++;
            if (dut.state !== exp_st) begin
                failures++;
                $display("FAIL rr_pair%0d got=%0d exp=%0d", p, dut.state, exp_st);
            end
            done_at = -1;
            for (int c = 2; c < 20; c++) begin
                @(negedge clk);
                if (!bus.MAIN_MEM_BUSY_WAIT) begin
                    done_at = c;
                    break;
                end
            end
            checks++;
            if (done_at != 5) begin
                failures++;
                $display("FAIL rr_done%0d got=%0d exp=5", p, done_at);
            end
            @(posedge clk); #1;
            bus.ICACHE_MEM_READ = 1'b0;
            bus.DCACHE_MEM_READ = 1'b0;
            @(negedge clk);
        end
    endtask
`endif

    task automatic test_writeback();
        int done_at = -1;
        @(posedge clk); #1;
        bus.DCACHE_MEM_WRITE = 1'b1;
        bus.DCACHE_MEM_READ = 1'b1;
        bus.DCACHE_MEM_ADDRESS = 28'h0000010;
        bus.DCACHE_MEM_WRITE_DATA = WBLK;
        @(negedge clk);
        @(posedge clk); #1;
        bus.ICACHE_MEM_READ = 1'b1;
        bus.ICACHE_MEM_ADDRESS = 28'h0000400;
        @(negedge clk);
        checks++;
        if (dut.state !== GRANT_D || bus.MAIN_MEM_WRITE !== 1'b1 ||
            bus.MAIN_MEM_READ !== 1'b0 || bus.MAIN_MEM_ADDRESS !== 28'h0000010) begin
            failures++;
            $display("FAIL wb_grant got st=%0d wr=%b rd=%b a=%h exp st=2 wr=1 rd=0 a=0000010",
                     dut.state, bus.MAIN_MEM_WRITE, bus.MAIN_MEM_READ,
                     bus.MAIN_MEM_ADDRESS);
        end
        checks++;
        if (bus.MAIN_MEM_WRITE_DATA !== WBLK || bus.ICACHE_MEM_BUSY_WAIT !== 1'b1) begin
            failures++;
            $display("FAIL wb_data got=%h ibusy=%b exp=%h ibusy=1",
                     bus.MAIN_MEM_WRITE_DATA, bus.ICACHE_MEM_BUSY_WAIT, WBLK);
        end
        for (int c = 2; c < 20; c++) begin
            @(negedge clk);
            if (!bus.DCACHE_MEM_BUSY_WAIT) begin
                done_at = c;
                break;
            end
        end
        checks++;
        if (done_at != 5) begin
            failures++;
            $display("FAIL wb_done got=%0d exp=5", done_at);
        end
        @(posedge clk); #1;
        bus.DCACHE_MEM_WRITE = 1'b0;
        bus.DCACHE_MEM_READ = 1'b0;
        @(negedge clk);
        @(posedge clk); #1;
        bus.DCACHE_MEM_READ = 1'b1;
        bus.DCACHE_MEM_ADDRESS = 28'h0000020;
        @(negedge clk);
        checks++;
        if (dut.state !== GRANT_I || bus.MAIN_MEM_ADDRESS !== 28'h0000400 ||
            bus.DCACHE_MEM_BUSY_WAIT !== 1'b1) begin
            failures++;
            $display("FAIL wb_i_between got st=%0d a=%h dbusy=%b exp st=1 a=0000400 dbusy=1",
                     dut.state, bus.MAIN_MEM_ADDRESS, bus.DCACHE_MEM_BUSY_WAIT);
        end
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (!bus.ICACHE_MEM_BUSY_WAIT) break;
        end
        @(posedge clk); #1;
        bus.ICACHE_MEM_READ = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (dut.state !== GRANT_D || bus.MAIN_MEM_READ !== 1'b1 ||
            bus.MAIN_MEM_WRITE !== 1'b0 || bus.MAIN_MEM_ADDRESS !== 28'h0000020) begin
            failures++;
            $display("FAIL wb_refill got st=%0d rd=%b wr=%b a=%h exp st=2 rd=1 wr=0 a=0000020",
                     dut.state, bus.MAIN_MEM_READ, bus.MAIN_MEM_WRITE,
                     bus.MAIN_MEM_ADDRESS);
        end
        done_at = -1;
        for (int c = 2; c < 20; c++) begin
            @(negedge clk);
            if (!bus.DCACHE_MEM_BUSY_WAIT) begin
                done_at = c;
                break;
            end
        end
        checks++;
        if (done_at != 5 || bus.DCACHE_MEM_READ_DATA !== RDATA) begin
            failures++;
            $display("FAIL wb_refill_done got at=%0d d=%h exp at=5 d=%h",
                     done_at, bus.DCACHE_MEM_READ_DATA, RDATA);
        end
        @(posedge clk); #1;
        bus.DCACHE_MEM_READ = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_abort();
        @(posedge clk); #1;
        bus.ICACHE_MEM_READ = 1'b1;
        bus.ICACHE_MEM_ADDRESS = 28'h0000500;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (dut.state !== GRANT_I || bus.ICACHE_MEM_BUSY_WAIT !== 1'b1) begin
            failures++;
            $display("FAIL abort_grant got st=%0d busy=%b exp st=1 busy=1",
                     dut.state, bus.ICACHE_MEM_BUSY_WAIT);
        end
        @(posedge clk); #1;
        bus.ICACHE_MEM_READ = 1'b0;
        #1;
        checks++;
        if (bus.MAIN_MEM_READ !== 1'b0 || bus.ICACHE_MEM_BUSY_WAIT !== 1'b0) begin
            failures++;
            $display("FAIL abort_comb got rd=%b busy=%b exp rd=0 busy=0",
                     bus.MAIN_MEM_READ, bus.ICACHE_MEM_BUSY_WAIT);
        end
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (dut.state !== IDLE || bus.ICACHE_MEM_BUSY_WAIT !== 1'b0) begin
            failures++;
            $display("FAIL abort_idle got st=%0d busy=%b exp st=0 busy=0",
                     dut.state, bus.ICACHE_MEM_BUSY_WAIT);
        end
    endtask

    task automatic test_reset_mid();
        int done_at = -1;
        @(posedge clk); #1;
        bus.DCACHE_MEM_WRITE = 1'b1;
        bus.DCACHE_MEM_ADDRESS = 28'h0000030;
        bus.DCACHE_MEM_WRITE_DATA = WBLK;
        @(negedge clk);
        @(negedge clk);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (dut.state !== IDLE || bus.MAIN_MEM_WRITE !== 1'b0 ||
            bus.DCACHE_MEM_BUSY_WAIT !== 1'b1) begin
            failures++;
            $display("FAIL rstmid_async got st=%0d wr=%b busy=%b exp st=0 wr=0 busy=1",
                     dut.state, bus.MAIN_MEM_WRITE, bus.DCACHE_MEM_BUSY_WAIT);
        end
        @(negedge clk);
        checks++;
        if (bus.DCACHE_MEM_BUSY_WAIT !== 1'b1) begin
            failures++;
            $display("FAIL rstmid_nodone got busy=%b exp=1", bus.DCACHE_MEM_BUSY_WAIT);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (dut.state !== GRANT_D || bus.MAIN_MEM_WRITE !== 1'b1) begin
            failures++;
            $display("FAIL rstmid_regrant got st=%0d wr=%b exp st=2 wr=1",
                     dut.state, bus.MAIN_MEM_WRITE);
        end
        for (int c = 2; c < 20; c++) begin
            @(negedge clk);
            if (!bus.DCACHE_MEM_BUSY_WAIT) begin
                done_at = c;
                break;
            end
        end
        checks++;
        if (done_at != 5) begin
            failures++;
            $display("FAIL rstmid_done got=%0d exp=5", done_at);
        end
        @(posedge clk); #1;
        bus.DCACHE_MEM_WRITE = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_single_i();
`ifndef ROUND_ROBIN_ARB_EN
        test_fixed_priority();
`else
        test_round_robin();
`endif
        test_writeback();
        test_abort();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/main_memory_arbiter.md
MAIN_MEMORY_ARBITER -- requirements
Module: main_memory_arbiter

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with ports named clock and reset.
REQ-002 clock  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 ICACHE_MEM_READ  input  1  instruction-cache block-read request.
REQ-005 ICACHE_MEM_ADDRESS  input  28  instruction-cache block address (tag and index).
REQ-006 ICACHE_MEM_READ_DATA  output  128  block returned to the instruction cache.
REQ-007 ICACHE_MEM_BUSY_WAIT  output  1  instruction-cache stall.
REQ-008 DCACHE_MEM_READ / DCACHE_MEM_WRITE  input  1 each  data-cache block read / write-back request.
REQ-009 DCACHE_MEM_ADDRESS  input  28; DCACHE_MEM_WRITE_DATA  input  128; DCACHE_MEM_READ_DATA  output  128; DCACHE_MEM_BUSY_WAIT  output  1.
REQ-010 MAIN_MEM_READ / MAIN_MEM_WRITE  output  1 each; MAIN_MEM_ADDRESS  output  28; MAIN_MEM_WRITE_DATA  output  128.
REQ-011 MAIN_MEM_READ_DATA  input  128; MAIN_MEM_BUSY_WAIT  input  1  memory busy, low in the cycle its access completes.

Function
REQ-012 The FSM SHALL have three states: IDLE, GRANT_I and GRANT_D.
REQ-013 In IDLE with a request pending, the FSM SHALL move to GRANT_I or GRANT_D at the next edge; a D request is DCACHE_MEM_READ or DCACHE_MEM_WRITE.
REQ-014 In IDLE, MAIN_MEM_READ and MAIN_MEM_WRITE SHALL both be 0.
REQ-015 In a grant state, the memory outputs SHALL combinationally mirror the granted requester's read, write, address and write data; the non-granted requester's inputs SHALL be ignored.
REQ-016 A registered flag "issued" SHALL be set on the first edge spent in a grant state.
REQ-017 Completion is the grant state with issued=1 and MAIN_MEM_BUSY_WAIT=0; at completion the FSM SHALL return to IDLE at the next edge and clear issued.
REQ-018 Requester busywait SHALL be 1 whenever that requester's request is high, except in the completion cycle of its own grant.
REQ-019 Busywait SHALL be 0 when that requester has no request.
REQ-020 MAIN_MEM_READ_DATA SHALL be broadcast to both READ_DATA outputs; busywait qualifies it.
REQ-021 If the granted requester drops its request before completion (abort), the memory outputs SHALL go idle combinationally and the FSM SHALL return to IDLE at the next edge.
REQ-022 Each transaction SHALL pass through IDLE for at least one cycle, so a D write-back followed by a refill is two grants and an I request may be served between them.
REQ-023 If D asserts read and write together, write SHALL take precedence and read SHALL be forwarded as 0.
REQ-024 Minimum latency from request to completion SHALL be 2 cycles plus the memory's busy time.

Reset
REQ-025 Reset assertion SHALL asynchronously force state=IDLE, issued=0 and the last-grant register to D.
REQ-026 During reset, MAIN_MEM_READ and MAIN_MEM_WRITE SHALL be 0 and both busywaits SHALL follow REQ-018 and REQ-019 with no grant held.
REQ-027 Reset mid-transaction SHALL abandon the access; no completion SHALL be signalled.

Configuration
REQ-028 With ROUND_ROBIN_ARB_EN defined and both requesting in IDLE, the grant SHALL go to the requester not granted last; the last-grant register updates on each grant.
REQ-029 Without ROUND_ROBIN_ARB_EN, D SHALL have fixed priority over I and the last-grant register SHALL not be built.

Structure
REQ-030 A shared package arb_pkg SHALL hold the state encoding (IDLE=2'b00, GRANT_I=2'b01, GRANT_D=2'b10), MEM_ADDR_W=28 and MEM_BLOCK_W=128.
REQ-031 A single sub-module, arb_grant_select, SHALL hold the combinational priority / round-robin pick.

Verification
REQ-032 I request alone with memory busy for 4 cycles: GRANT_I 1 cycle after the request, ICACHE_MEM_BUSY_WAIT low in exactly one cycle, ICACHE_MEM_READ_DATA=0xDEADBEEF_..._CAFE in that cycle, FSM back in IDLE.
REQ-033 I and D read in the same cycle, fixed priority: D served first, I granted after one IDLE cycle, I busywait high throughout the D transaction.
REQ-034 With ROUND_ROBIN_ARB_EN, three back-to-back simultaneous request pairs: grants alternate D, I, D.
REQ-035 D write-back to address 0x0000010 then refill of 0x0000020, with an I request pending: order is D write, I read, D read; MAIN_MEM_WRITE_DATA matches the write-back block.
REQ-036 I drops its request 1 cycle into GRANT_I: MAIN_MEM_READ goes 0 in the same cycle, the FSM is in IDLE at the next edge, and no busywait glitch occurs.
REQ-037 reset asserted low during GRANT_D with memory busy: state is IDLE immediately, MAIN_MEM_WRITE is 0, and a new grant is issued after reset releases.
